// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and iteration-counter sizing shared by alu_seq and its mul/div engine.
package alu_seq_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: shared iterative engine, shift-add multiply (mode 0) or restoring divide (mode 1), one bit per step.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n,
  output logic             last
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   add, rem;
  // hi/lo hold the partial product (mul) or remainder/quotient-in-progress (div); *_n is the value after this step
  always_comb begin
    add  = {1'b0, hi_q} + {1'b0, lo_q[0] ? m_q : '0};
    rem  = {hi_q, lo_q[WIDTH-1]} - {1'b0, m_q};
    hi_n = mode_q ? (rem[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : rem[WIDTH-1:0]) : add[WIDTH:1];
    lo_n = mode_q ? {lo_q[WIDTH-2:0], ~rem[WIDTH]} : {add[0], lo_q[WIDTH-1:1]};
  end
  assign last = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      m_q    <= b;
      mode_q <= mode;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q   <= hi_n;
      lo_q   <= lo_n;
      cnt_q  <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with start/done handshake and iterative mul/div.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op 101 behaves as add and DivZero stays 0.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Carry,
  output logic             DivZero,
  output logic             busy,
  output logic             done
);
  localparam int SHW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, alu, eng_hi, eng_lo;
  logic [WIDTH:0]   sum, diff;
  logic             zero_q, zero_d, carry_q, carry_d, divz_q, divz_d;
  logic             cy, load, step, mode, last;
  always_comb begin
    sum  = {1'b0, A} + {1'b0, B};
    diff = {1'b0, A} - {1'b0, B};
    alu  = ALUControl == ALU_SUB ? diff[WIDTH-1:0]
         : ALUControl == ALU_SLT ? {{(WIDTH-1){1'b0}}, diff[WIDTH]}
         : ALUControl == ALU_SLL ? (B >= WIDTH'(WIDTH) ? '0 : A << B[SHW-1:0])
         : ALUControl == ALU_AND ? A & B
         : ALUControl == ALU_OR  ? A | B
         : sum[WIDTH-1:0];
    cy   = ALUControl == ALU_SUB ? diff[WIDTH]
         : (ALUControl == ALU_ADD || ALUControl == ALU_DIV) && sum[WIDTH];
  end
  // a start is honoured only from IDLE or DONE, so starts during MUL/DIV fall through and are dropped
  always_comb begin
    state_d = state_q == S_DONE ? S_IDLE : state_q;
    {res_d, hi_d, carry_d, divz_d} = {res_q, hi_q, carry_q, divz_q};
    load = 1'b0;
    step = 1'b0;
    mode = 1'b0;
    if (state_q == S_MUL || state_q == S_DIV) begin
      step = 1'b1;
      if (last) begin
        state_d = S_DONE;
        res_d   = eng_lo;
        hi_d    = eng_hi;
        carry_d = 1'b0;
        divz_d  = 1'b0;
      end
    end else if (start) begin
      if (ALUControl == ALU_MUL) begin
        load    = 1'b1;
        state_d = S_MUL;
      end
`ifdef ALU_SEQ_DIV_EN
      else if (ALUControl == ALU_DIV && B != '0) begin
        load    = 1'b1;
        mode    = 1'b1;
        state_d = S_DIV;
      end else if (ALUControl == ALU_DIV) begin
        state_d = S_DONE;
        res_d   = '1;
        hi_d    = A;
        carry_d = 1'b0;
        divz_d  = 1'b1;
      end
`endif
      else begin
        state_d = S_DONE;
        res_d   = alu;
        hi_d    = '0;
        carry_d = cy;
        divz_d  = 1'b0;
      end
    end
    zero_d = state_d == S_DONE ? res_d == '0 : zero_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      divz_q  <= divz_d;
    end
  end
  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clock),
    .rst_n (reset_n),
    .load  (load),
    .mode  (mode),
    .step  (step),
    .a     (A),
    .b     (B),
    .hi_n  (eng_hi),
    .lo_n  (eng_lo),
    .last  (last)
  );
  assign Result   = res_q;
  assign ResultHi = hi_q;
  assign Zero     = zero_q;
  assign Carry    = carry_q;
  assign DivZero  = divz_q;
  assign busy     = state_q == S_MUL || state_q == S_DIV;
  assign done     = state_q == S_DONE;
endmodule
